// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo_queue write port among NUM_REQUESTERS producers.
// Optional burst mode (repeat grants to the previous grantee) is enabled by defining FIFO_ARB_BURST_EN.
module fifo_write_arbiter #(
    parameter int NUM_REQUESTERS               = 4,
    parameter int NUM_REQUESTERS_WIDTH_IN_BITS = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS   = 32,
    parameter int MAX_BURST                    = 4
) (
    input  logic                                                   clk_in,
    input  logic                                                   reset_in,
    input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   request_in,
    input  logic [NUM_REQUESTERS-1:0]                              request_valid_in,
    output logic [NUM_REQUESTERS-1:0]                              issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                  fifo_request_out,
    output logic                                                   fifo_request_valid_out,
    input  logic                                                   fifo_issue_ack_in,
    input  logic                                                   fifo_is_full_in,
    output logic [NUM_REQUESTERS_WIDTH_IN_BITS-1:0]                grant_id_out,
    output logic                                                   busy_out
);

    localparam int N  = NUM_REQUESTERS;
    localparam int IW = NUM_REQUESTERS_WIDTH_IN_BITS;
    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_ACK   = 2'd2;

    localparam logic [IW-1:0] LAST_INDEX   = IW'(N - 1);
    localparam logic [N-1:0]  ONE_HOT_BASE = N'(1);

    logic [1:0]    state;
    logic [IW-1:0] last_grant;

    logic [2*N-1:0] valid_twice;
    logic [IW:0]    rotate_amount;
    logic [N-1:0]   rotated_valid;
    logic [N-1:0]   rr_scan;
    int             rr_sum;
    logic           rr_found;
    logic [IW-1:0]  rr_index;

    logic           pick_valid;
    logic [IW-1:0]  pick_index;
    logic [W-1:0]   pick_entry;
    logic           grant_fire;

    // Rotating a doubled copy puts producer last_grant+1 at bit 0, which also
    // works when N is not a power of two.
    assign valid_twice   = {request_valid_in, request_valid_in};
    assign rotate_amount = {1'b0, last_grant} + {{IW{1'b0}}, 1'b1};
    assign rotated_valid = N'(valid_twice >> rotate_amount);

    always_comb begin
        rr_found = 1'b0;
        rr_index = '0;
        rr_sum   = 0;
        rr_scan  = rotated_valid;
        for (int j = 0; j < N; j++) begin
            if (!rr_found && rr_scan[0]) begin
                rr_found = 1'b1;
                rr_sum   = int'(last_grant) + 1 + j;
                if (rr_sum >= N) begin
                    rr_sum = rr_sum - N;
                end
                rr_index = IW'(rr_sum);
            end
            rr_scan = rr_scan >> 1;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] burst_count;
    logic          prev_valid;
    logic          burst_again;

    // A zero count means nobody has been granted since reset, so there is no
    // previous grantee to favour.
    assign prev_valid  = |(request_valid_in & (ONE_HOT_BASE << last_grant));
    assign burst_again = prev_valid && (burst_count != '0) && (burst_count < BW'(MAX_BURST));
    assign pick_valid  = burst_again || rr_found;
    assign pick_index  = burst_again ? last_grant : rr_index;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            burst_count <= '0;
        end else if (grant_fire) begin
            burst_count <= burst_again ? (burst_count + BW'(1)) : BW'(1);
        end
    end
`else
    logic unused_max_burst;

    assign unused_max_burst = (MAX_BURST > 0);
    assign pick_valid       = rr_found;
    assign pick_index       = rr_index;
`endif

    assign pick_entry = W'(request_in >> (int'(pick_index) * W));
    assign grant_fire = (state == STATE_IDLE) && pick_valid && !fifo_is_full_in;
    assign busy_out   = (state == STATE_ISSUE) || (state == STATE_ACK);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state                  <= STATE_IDLE;
            issue_ack_out          <= '0;
            fifo_request_out       <= '0;
            fifo_request_valid_out <= 1'b0;
            grant_id_out           <= '0;
            last_grant             <= LAST_INDEX;
        end else begin
            case (state)
                STATE_IDLE: begin
                    issue_ack_out <= '0;
                    if (grant_fire) begin
                        fifo_request_out       <= pick_entry;
                        fifo_request_valid_out <= 1'b1;
                        grant_id_out           <= pick_index;
                        state                  <= STATE_ISSUE;
                    end
                end
                STATE_ISSUE: begin
                    // The entry was latched at grant time, so a producer that
                    // drops valid here still has its data delivered and acked.
                    if (fifo_issue_ack_in) begin
                        fifo_request_valid_out <= 1'b0;
                        issue_ack_out          <= ONE_HOT_BASE << grant_id_out;
                        last_grant             <= grant_id_out;
                        state                  <= STATE_ACK;
                    end
                end
                STATE_ACK: begin
                    issue_ack_out <= '0;
                    state         <= STATE_IDLE;
                end
                default: begin
                    issue_ack_out          <= '0;
                    fifo_request_valid_out <= 1'b0;
                    state                  <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule
